// File: rtl/pool_stream_pkg.sv
// Shared definitions for the pool_stream pooling unit: mode encodings and
// width helpers used when sizing the average-mode accumulators.
package pool_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // A K x K window sum of PW-bit signed pixels grows by log2(K) bits per axis.
    function automatic int sum_width(input int pw, input int k);
        return pw + 2 * clog2(k);
    endfunction

endpackage

// File: rtl/pool_stream_if.sv
// Pixel-in / pooled-out stream bundle of pool_stream; slave is the pooling
// unit's view, master is the upstream/downstream environment's view.
interface pool_stream_if #(
    parameter int CH = 1,
    parameter int PW = 9
);
    logic              mode;
    logic              in_valid;
    logic              in_sof;
    logic [CH*PW-1:0]  pxl_in;
    logic [CH*PW-1:0]  pool_out;
    logic              valid;
    logic              out_last;

    modport slave (
        input  mode, in_valid, in_sof, pxl_in,
        output pool_out, valid, out_last
    );

    modport master (
        output mode, in_valid, in_sof, pxl_in,
        input  pool_out, valid, out_last
    );

endinterface

// File: rtl/pool_stream_line_buffer.sv
// pool_line_buffer: (ROWS)-row by DIM-column shift memory; each write pushes the
// column's history down one row and the taps expose the older rows at that column.
module pool_line_buffer #(
    parameter int DIM  = 16,
    parameter int ROWS = 1,
    parameter int W    = 9,
    parameter int AW   = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            addr,
    input  logic [W-1:0]             din,
    output logic [ROWS-1:0][W-1:0]   taps
);

    logic [W-1:0] mem [ROWS][DIM];

    // NOTE: storage arrays get no reset; every location read by a window has
    // been rewritten earlier in the same frame, so a reset would only cost area.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0][addr] <= din;
            for (int j = 1; j < ROWS; j++) begin
                mem[j][addr] <= mem[j-1][addr];
            end
        end
    end

    // taps[j] is the pixel j+1 rows above the current one in this column.
    always_comb begin
        taps = '0;
        for (int j = 0; j < ROWS; j++) begin
            taps[j] = mem[j][addr];
        end
    end

endmodule

// File: rtl/pool_stream.sv
// Streaming 2-D max/average pooling over CH packed channels. Average mode is
// only built when POOL_AVG_EN is defined; otherwise the unit is max-only.
module pool_stream
    import pool_pkg::*;
#(
    parameter int DIM    = 16,
    parameter int K      = 2,
    parameter int STRIDE = 2,
    parameter int PW     = 9,
    parameter int CH     = 1
) (
    input  logic          clk,
    input  logic          reset,
    pool_stream_if.slave  s
);

    localparam int AW   = (clog2(DIM) > 0) ? clog2(DIM) : 1;
    localparam int ROWS = (K > 1) ? K - 1 : 1;
    localparam int LAST = ((DIM - K) / STRIDE) * STRIDE + K - 1;
    localparam int W    = CH * PW;
`ifdef POOL_AVG_EN
    localparam int LK   = clog2(K);
    localparam int CW   = sum_width(PW, K);
`else
    localparam int CW   = PW;
`endif

    typedef logic signed [CW-1:0] col_t;
    typedef logic signed [PW-1:0] pix_t;

    logic [AW-1:0]          row_q, col_q;
    logic [AW-1:0]          cur_row, cur_col;
    logic                   at_origin, win_hit, win_last, kill;
    logic                   cur_mode;
    logic [ROWS-1:0][W-1:0] taps;
    col_t                   col_val [CH];
    col_t                   col_sr  [K][CH];
    pix_t                   red_d   [CH];
    pix_t                   red_q   [CH];
    logic [W-1:0]           red_packed;
    logic                   s0_v, s0_last;
    logic                   red_v, red_last;

    // sof overrides the counters so the pixel is treated as (0,0).
    always_comb begin
        cur_row   = s.in_sof ? '0 : row_q;
        cur_col   = s.in_sof ? '0 : col_q;
        at_origin = (cur_row == '0) && (cur_col == '0);
        win_hit   = (int'(cur_row) >= K - 1) && (int'(cur_col) >= K - 1)
                 && ((int'(cur_row) - K + 1) % STRIDE == 0)
                 && ((int'(cur_col) - K + 1) % STRIDE == 0);
        win_last  = (int'(cur_row) == LAST) && (int'(cur_col) == LAST);
        // An sof away from (0,0) abandons a partial frame and squashes its in-flight windows.
        kill      = s.in_valid && s.in_sof && ((row_q != '0) || (col_q != '0));
    end

`ifdef POOL_AVG_EN
    logic frame_mode_q;
    logic s0_mode;
    assign cur_mode = at_origin ? s.mode : frame_mode_q;
`else
    logic unused_mode;
    assign unused_mode = s.mode;
    assign cur_mode    = POOL_MAX;
`endif

    pool_line_buffer #(
        .DIM  (DIM),
        .ROWS (ROWS),
        .W    (W),
        .AW   (AW)
    ) u_line_buffer (
        .clk  (clk),
        .we   (s.in_valid),
        .addr (cur_col),
        .din  (s.pxl_in),
        .taps (taps)
    );

    // Vertical reduction of the current pixel with the K-1 rows above it.
    always_comb begin
        pix_t v, mx;
`ifdef POOL_AVG_EN
        col_t sm;
`endif
        for (int ch = 0; ch < CH; ch++) begin
            // NOTE: scratch variables are assigned before any read on every pass,
            // so this block stays purely combinational with blocking updates.
            v  = '0;
            mx = pix_t'(s.pxl_in[ch*PW +: PW]);
`ifdef POOL_AVG_EN
            sm = col_t'(mx);
`endif
            for (int j = 0; j < K - 1; j++) begin
                v = pix_t'(taps[j][ch*PW +: PW]);
                if (v > mx) mx = v;
`ifdef POOL_AVG_EN
                sm = sm + col_t'(v);
`endif
            end
`ifdef POOL_AVG_EN
            col_val[ch] = (cur_mode == POOL_AVG) ? sm : col_t'(mx);
`else
            col_val[ch] = mx;
`endif
        end
    end

    // Horizontal reduction across the K most recent column results.
    always_comb begin
        col_t hm;
`ifdef POOL_AVG_EN
        col_t hs, sh;
`endif
        for (int ch = 0; ch < CH; ch++) begin
            hm = col_sr[0][ch];
`ifdef POOL_AVG_EN
            hs = col_sr[0][ch];
`endif
            for (int i = 1; i < K; i++) begin
                if (col_sr[i][ch] > hm) hm = col_sr[i][ch];
`ifdef POOL_AVG_EN
                hs = hs + col_sr[i][ch];
`endif
            end
`ifdef POOL_AVG_EN
            // Arithmetic shift floors toward -inf; the mean always fits PW bits.
            sh = hs >>> (2 * LK);
            red_d[ch] = (s0_mode == POOL_AVG) ? sh[PW-1:0] : hm[PW-1:0];
`else
            red_d[ch] = hm[PW-1:0];
`endif
        end
    end

    always_comb begin
        red_packed = '0;
        for (int ch = 0; ch < CH; ch++) begin
            red_packed[ch*PW +: PW] = red_q[ch];
        end
    end

    // Datapath registers: column shift register freezes on gaps, reduction stage free-runs.
    always_ff @(posedge clk) begin
        if (s.in_valid) begin
            col_sr[0] <= col_val;
            for (int i = 1; i < K; i++) begin
                col_sr[i] <= col_sr[i-1];
            end
        end
        if (s0_v) begin
            red_q <= red_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q      <= '0;
            col_q      <= '0;
            s0_v       <= 1'b0;
            s0_last    <= 1'b0;
            red_v      <= 1'b0;
            red_last   <= 1'b0;
            s.valid    <= 1'b0;
            s.out_last <= 1'b0;
            s.pool_out <= '0;
`ifdef POOL_AVG_EN
            frame_mode_q <= POOL_MAX;
            s0_mode      <= POOL_MAX;
`endif
        end else begin
            s0_v       <= s.in_valid && win_hit;
            red_v      <= s0_v && !kill;
            red_last   <= s0_last;
            s.valid    <= red_v && !kill;
            s.out_last <= red_v && red_last && !kill;
            if (red_v) begin
                s.pool_out <= red_packed;
            end
            if (s.in_valid) begin
                s0_last <= win_last;
                if (int'(cur_col) == DIM - 1) begin
                    col_q <= '0;
                    row_q <= (int'(cur_row) == DIM - 1) ? '0 : cur_row + 1'b1;
                end else begin
                    col_q <= cur_col + 1'b1;
                    row_q <= cur_row;
                end
`ifdef POOL_AVG_EN
                if (at_origin) frame_mode_q <= s.mode;
                s0_mode <= cur_mode;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream: two instances (DIM=4, K=2; stride 2 x1 channel
// and stride 1 x2 channels) driven with directed frames and hand-computed results.
module tb_pool_stream;

    localparam int PW = 9;

    typedef struct {
        int     d0;
        int     d1;
        bit     last;
        longint cyc;
    } exp_t;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    longint cyc   = 0;
    int     n_cmp = 0;
    int     n_err = 0;
    exp_t   q_a[$];
    exp_t   q_b[$];

    int ramp[16];
    int neg_px[16] = '{-1, -2, 3, -4, -1, -2, 5, -8, 255, 255, -256, -256, 255, 255, -256, -256};
    int max_ev[4]  = '{6, 8, 14, 16};
    int avg_ev[4];
    int neg_ev[4];
    int b0_ev[9]   = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    int b1_ev[9]   = '{-1, -2, -3, -5, -6, -7, -9, -10, -11};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool_stream_if #(.CH(1), .PW(PW)) ifa ();
    pool_stream_if #(.CH(2), .PW(PW)) ifb ();

    pool_stream #(.DIM(4), .K(2), .STRIDE(2), .PW(PW), .CH(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .s     (ifa.slave)
    );

    pool_stream #(.DIM(4), .K(2), .STRIDE(1), .PW(PW), .CH(2)) dut_b (
        .clk   (clk),
        .reset (reset),
        .s     (ifb.slave)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expectation per valid pulse and compare value, last flag and latency.
    always @(negedge clk) begin
        exp_t e;
        if (reset && ifa.valid) begin
            if (q_a.size() == 0) begin
                check("a_spurious_valid", ifa.valid, 0);
            end else begin
                e = q_a.pop_front();
                check("a_data", $signed(ifa.pool_out), e.d0);
                check("a_last", ifa.out_last, e.last);
                check("a_latency", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset && ifb.valid) begin
            if (q_b.size() == 0) begin
                check("b_spurious_valid", ifb.valid, 0);
            end else begin
                e = q_b.pop_front();
                check("b_data_ch0", $signed(ifb.pool_out[PW-1:0]), e.d0);
                check("b_data_ch1", $signed(ifb.pool_out[2*PW-1:PW]), e.d1);
                check("b_last", ifb.out_last, e.last);
                check("b_latency", cyc, e.cyc);
            end
        end
    end

    task automatic drive_a(input bit v, input bit sof, input bit md, input int px);
        ifa.in_valid = v;
        ifa.in_sof   = sof;
        ifa.mode     = md;
        ifa.pxl_in   = 9'(px);
        @(negedge clk);
    endtask

    task automatic drive_b(input bit v, input bit sof, input int px);
        ifb.in_valid = v;
        ifb.in_sof   = sof;
        ifb.mode     = 1'b0;
        ifb.pxl_in   = {9'(-px), 9'(px)};
        @(negedge clk);
    endtask

    // Windows of the stride-2 instance complete on raster pixels 5, 7, 13, 15.
    task automatic frame_a(input int px[16], input int ev[4], input bit md0, input bit md1,
                           input int gap, input int n, input bit sof0, input bit push);
        int   k;
        exp_t e;
        k = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 8 && gap > 0 && $urandom_range(99) < gap; g++) begin
                drive_a(1'b0, 1'b0, md1, 0);
            end
            drive_a(1'b1, sof0 && (i == 0), (i == 0) ? md0 : md1, px[i]);
            if (push && (i == 5 || i == 7 || i == 13 || i == 15)) begin
                e.d0   = ev[k];
                e.d1   = 0;
                e.last = (i == 15);
                e.cyc  = cyc + 2;
                q_a.push_back(e);
                k++;
            end
        end
        ifa.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;
    endtask

    // Stride 1: every pixel with row >= 1 and col >= 1 completes a window.
    task automatic frame_b(input int px[16], input int e0[9], input int e1[9],
                           input int n, input bit sof0);
        int   k;
        exp_t e;
        k = 0;
        for (int i = 0; i < n; i++) begin
            drive_b(1'b1, sof0 && (i == 0), px[i]);
            if (i >= 5 && (i % 4) != 0) begin
                e.d0   = e0[k];
                e.d1   = e1[k];
                e.last = (i == 15);
                e.cyc  = cyc + 2;
                q_b.push_back(e);
                k++;
            end
        end
        ifb.in_valid = 1'b0;
        ifb.in_sof   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ramp[i] = i + 1;
`ifdef POOL_AVG_EN
        avg_ev = '{3, 5, 11, 13};
        neg_ev = '{-2, -1, 255, -256};
`else
        avg_ev = '{6, 8, 14, 16};
        neg_ev = '{-1, 5, 255, -256};
`endif
        ifa.in_valid = 1'b0; ifa.in_sof = 1'b0; ifa.mode = 1'b0; ifa.pxl_in = '0;
        ifb.in_valid = 1'b0; ifb.in_sof = 1'b0; ifb.mode = 1'b0; ifb.pxl_in = '0;

        repeat (3) @(negedge clk);
        check("a_reset_valid",    ifa.valid,    0);
        check("a_reset_last",     ifa.out_last, 0);
        check("a_reset_pool_out", ifa.pool_out, 0);
        check("b_reset_valid",    ifb.valid,    0);
        check("b_reset_pool_out", ifb.pool_out, 0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back frames on the stride-2 instance.
        frame_a(ramp,   max_ev, 1'b0, 1'b0, 0,  16, 1'b1, 1'b1);
        frame_a(ramp,   avg_ev, 1'b1, 1'b0, 0,  16, 1'b1, 1'b1);
        frame_a(ramp,   max_ev, 1'b0, 1'b1, 0,  16, 1'b1, 1'b1);
        frame_a(neg_px, neg_ev, 1'b1, 1'b1, 0,  16, 1'b1, 1'b1);
        frame_a(ramp,   max_ev, 1'b0, 1'b0, 50, 16, 1'b1, 1'b1);
        // Six pixels then an sof: the abandoned frame must emit nothing.
        frame_a(ramp,   max_ev, 1'b0, 1'b0, 0,  6,  1'b1, 1'b0);
        frame_a(ramp,   max_ev, 1'b0, 1'b0, 0,  16, 1'b1, 1'b1);
        repeat (4) @(negedge clk);

        // Two-channel stride-1 instance, then an asynchronous reset mid-frame.
        frame_b(ramp, b0_ev, b1_ev, 16, 1'b1);
        frame_b(ramp, b0_ev, b1_ev, 16, 1'b1);
        frame_b(ramp, b0_ev, b1_ev, 8,  1'b1);
        #1 reset = 1'b0;
        #1;
        check("b_async_reset_valid",    ifb.valid,    0);
        check("b_async_reset_last",     ifb.out_last, 0);
        check("b_async_reset_pool_out", ifb.pool_out, 0);
        q_b.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        frame_b(ramp, b0_ev, b1_ev, 16, 1'b0);

        repeat (6) @(negedge clk);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pool_stream.md
# pool_stream

Streaming 2-D pooling unit, the parametrised successor to `max_pool`. It consumes one raster-order pixel per accepted cycle for `CH` parallel channels and emits one pooled value per channel per window. It supports max or average mode, arbitrary window and stride, gapped input and mid-stream frame resync. It sits between a convolution stage and the next layer's input stream.

## Interface
- `DIM`, 16: image width and height, in pixels.
- `K`, 2: window edge. Must be a power of 2 when average mode is compiled in.
- `STRIDE`, 2: window step, in both dimensions.
- `PW`, 9: signed pixel width.
- `CH`, 1: channels processed in parallel, packed LSB-first.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: asynchronous, active-low reset.
- `mode  in  1`: 0 = max, 1 = average. Sampled only on a frame's first accepted pixel.
- `in_valid  in  1`: `pxl_in` is accepted this cycle.
- `in_sof  in  1`: qualified by `in_valid`; the current pixel is (row 0, col 0) of a new frame.
- `pxl_in  in  CH*PW`: channel c occupies bits `[c*PW +: PW]`.
- `pool_out  out  CH*PW`: pooled result, same packing as `pxl_in`.
- `valid  out  1`: `pool_out` holds a new result this cycle (single-cycle pulse).
- `out_last  out  1`: with `valid`, marks the final window of the frame.

## Operation
- Counters `row` and `col`, range 0..DIM-1, advance only on `in_valid`.
  - `col` wraps to 0 and increments `row`.
  - After pixel (DIM-1, DIM-1), both return to 0.
- `in_valid && in_sof` forces the current pixel to (0,0) regardless of the counters. Any partial frame is abandoned and no outputs are emitted for it after that point.
- A window completes on the accepted pixel at (r,c) when all of the following hold:
  - r ≥ K-1 and c ≥ K-1;
  - (r-K+1) % STRIDE == 0;
  - (c-K+1) % STRIDE == 0.
- Outputs per frame: ((DIM-K)/STRIDE+1)², using floor division. Trailing rows and columns that cannot fill a window are dropped.
- Per-channel datapath:
  - K-1 line buffers of DIM entries each.
  - A vertical reduction of K rows for the current column.
  - A K-deep horizontal shift register of column results.
  - A horizontal reduction across that shift register.
- Max mode: signed comparison; the result is PW bits.
- Average mode:
  - Sum in PW + 2·log2(K) bits.
  - Arithmetic shift right by 2·log2(K), which floors toward −∞.
  - The result fits in PW bits; no saturation is needed.
- The frame mode register latches `mode` on the pixel at (0,0), including a pixel forced there by sof. Changing `mode` mid-frame has no effect until the next frame.
- `out_last` asserts with `valid` for the window whose bottom-right pixel is the last window position of the frame.

## Timing
- Latency: `valid` asserts exactly 2 `clk` cycles after the edge that accepted the window-completing pixel. The 2 stages are the reduction stage and the output register.
- Input gaps, i.e. `in_valid`=0:
  - Freeze the counters and line buffers.
  - Do not stall the 2-stage output pipeline; results already in flight still emit on schedule.
- No backpressure: the downstream stage must accept on every `valid`.
- Back-to-back frames with no idle cycles are supported.
- Reset, asynchronous assert:
  - `valid`, `out_last` and `pool_out` go to 0.
  - Counters and the frame mode register (max) go to 0.
  - Pipeline valid bits clear.
  - Line-buffer contents are not reset; they are never read before being rewritten in the current frame.
- Reset mid-frame: the next accepted pixel is treated as (0,0).
- sof on a pixel that also completes a window under the old counters: sof wins and no output is produced for that pixel.

## Configuration
- `POOL_AVG_EN`:
  - Defined: the average path (adder tree, shift) is built and `mode` is honoured.
  - Undefined: there is no adder logic, `mode` is ignored, and the frame mode is always max. The power-of-2 restriction on `K` is lifted.

## Structure
- Shared package `pool_pkg` holds:
  - the mode encoding constants `POOL_MAX` = 0 and `POOL_AVG` = 1;
  - a `clog2` function;
  - the sum-width calculation.
- Sub-module `pool_line_buffer`: a DIM-deep, (K-1)-row shift memory per channel with a write enable tied to `in_valid`. It is instantiated once with a width of CH*PW.

## Test plan
- DIM=4, K=2, STRIDE=2, CH=1, max mode, pixels 1..16 on consecutive cycles -> `pool_out` 6, 8, 14, 16; `out_last` asserted only with 16; each result 2 cycles after pixels 6, 8, 14, 16.
- Same stimulus with `POOL_AVG_EN` defined, mode=1 -> outputs 3, 5, 11, 13.
- Average mode, window {-1, -2, -1, -2} -> sum -6, output -2 (floor); with `POOL_AVG_EN` undefined the same stimulus gives -1 (max).
- Random `in_valid` gaps (about 50%) on the first stimulus -> the same 4 values in order, each 2 cycles after its completing pixel is accepted.
- `in_sof` asserted on the 7th pixel, followed by a clean 16-pixel frame -> no output from the abandoned frame after the sof; the new frame gives 6, 8, 14, 16.
- CH=2, DIM=4, K=2, STRIDE=1, channel 1 = negated channel 0 -> 9 outputs per frame; channel 0 max 6, 7, 8, 10…; channel 1 max -1, -2, -3, -5…. Asserting `reset` low mid-frame clears `valid` immediately, and the following frame is correct.
